fifo_sync_flags: RTL and testbench
==================================

Name: fifo_sync_flags

Overview:
Parametrised single-clock FIFO that succeeds the fixed FIFO exercised by the current fifo test bench. It generalises data width and depth, and adds the following:
- programmable almost-full and almost-empty thresholds;
- an occupancy count;
- sticky overflow and underflow error flags;
- a selectable first-word-fall-through (FWFT) read mode.

It sits between a producer using the write modport and a consumer using the read modport of the FIFO interface.

Parameters:
DATA_W, 8, data word width in bits (≥1)
DEPTH, 16, number of storage entries; must be a power of two, ≥2
ADDR_W, $clog2(DEPTH), derived pointer width; not to be overridden
AF_TH, DEPTH-2, almost_full asserts when count ≥ AF_TH (range 1..DEPTH)
AE_TH, 2, almost_empty asserts when count ≤ AE_TH (range 0..DEPTH-1)
FWFT, 0, 0 = registered read with 1-cycle latency; 1 = first-word-fall-through

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
wr_en  input  1  write request
wr_data  input  DATA_W  write data
full  output  1  count == DEPTH
almost_full  output  1  count ≥ AF_TH
rd_en  input  1  read request (pop acknowledge in FWFT mode)
rd_data  output  DATA_W  read data
rd_valid  output  1  rd_data is valid
empty  output  1  count == 0
almost_empty  output  1  count ≤ AE_TH
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty
clr_err  input  1  clears overflow and underflow

Behaviour:
- Reset (rst=1 at a clock edge): wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0 (AF_TH≥1), rd_valid=0, rd_data=0 when FWFT=0, overflow=0, underflow=0.
  - Storage is not reset.
  - Reset mid-operation discards all contents and dominates every other input that cycle.
- Write accept: wr_acc = wr_en & ~full, using the registered full. On accept:
  - mem[wr_ptr] <= wr_data;
  - wr_ptr increments modulo DEPTH (natural ADDR_W wrap).
- Read accept: rd_acc = rd_en & ~empty. On accept, rd_ptr increments modulo DEPTH.
- Count update: count <= count + wr_acc - rd_acc.
  - Simultaneous accepted read and write leave count unchanged.
  - When full, a simultaneous read is accepted and the write is rejected, so count goes DEPTH→DEPTH-1. No write-through when full.
  - When empty, a simultaneous write is accepted and the read is rejected, so count goes 0→1. No read-through when empty.
- Flags: full, empty, almost_full and almost_empty are decoded from the registered count. They are valid the cycle after the causing access, with no other latency.
- FWFT=0 read path:
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1 in the next cycle.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
  - Read latency is 1 cycle; back-to-back reads give one word per cycle.
- FWFT=1 read path:
  - rd_data = mem[rd_ptr] combinationally; rd_valid = ~empty.
  - rd_en pops the presented word. rd_data is defined only while rd_valid=1.
  - A first write into an empty FIFO presents its word one cycle after the write edge.
- Error flags:
  - overflow <= 1 on wr_en & full.
  - underflow <= 1 on rd_en & empty.
  - clr_err=1 clears both, but a new error event in the same cycle wins (the flag stays 1).
  - Error flags do not block further operation.
- Wrap-around: pointers wrap silently. Data order must remain strictly first-in first-out across any number of wraps.
- Elaboration: the block issues $error and stops elaboration if DEPTH is not a power of two, DEPTH<2, AF_TH is outside 1..DEPTH, or AE_TH is outside 0..DEPTH-1.

Test Plan:
1. DEPTH=16, FWFT=0: reset, then write 0x00..0x0F over 16 cycles.
   - full=1 and count=16 after the last edge; almost_full rises when count reaches 14.
   - Read 16 words: rd_data sequence 0x00..0x0F, each 1 cycle after its rd_en; empty=1 at the end.
2. Fill to 16, then wr_en=1 with wr_data=0xAA for 1 cycle.
   - overflow=1, count stays 16, 0xAA is never read.
   - Pulse clr_err → overflow=0.
   - Then clr_err=1 together with wr_en while full → overflow stays 1.
3. From empty, rd_en=1 for 1 cycle → underflow=1, rd_valid stays 0, count stays 0.
   - Simultaneous wr_en(0x55)+rd_en while empty → count=1, underflow=1.
   - The next read returns 0x55.
4. Hold count=8 with wr_en=rd_en=1 continuously for 40 cycles using an incrementing pattern (pointers wrap 2+ times).
   - count stays 8 throughout; output order matches input order exactly.
5. Full, wr_en=rd_en=1 → count=15, full=0, oldest word is output. Fill to 10, assert rst for 1 cycle mid-traffic → count=0, empty=1, rd_valid=0, error flags=0.
6. FWFT=1:
   - Write 0x11 → rd_data=0x11 and rd_valid=1 one cycle after the write edge.
   - Write 0x22, pulse rd_en → rd_data=0x22 the next cycle.
   - Pulse rd_en again → rd_valid=0.

Source files
------------

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with occupancy count, threshold flags, sticky errors and optional FWFT read
module fifo_sync_flags #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int AF_TH  = DEPTH - 2,
  parameter int AE_TH  = 2,
  parameter bit FWFT   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_sync_flags: DEPTH must be a power of two and at least 2");
  end
  if (ADDR_W != $clog2(DEPTH)) begin : g_bad_addr_w
    $error("fifo_sync_flags: ADDR_W must equal clog2(DEPTH)");
  end
  if (AF_TH < 1 || AF_TH > DEPTH) begin : g_bad_af_th
    $error("fifo_sync_flags: AF_TH must lie in 1..DEPTH");
  end
  if (AE_TH < 0 || AE_TH > DEPTH - 1) begin : g_bad_ae_th
    $error("fifo_sync_flags: AE_TH must lie in 0..DEPTH-1");
  end
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              wr_acc, rd_acc;
  // Accepts use the registered flags, so a full FIFO never writes through and an empty one never reads through
  assign wr_acc       = wr_en & ~full;
  assign rd_acc       = rd_en & ~empty;
  assign full         = count == (ADDR_W+1)'(DEPTH);
  assign empty        = count == '0;
  assign almost_full  = count >= (ADDR_W+1)'(AF_TH);
  assign almost_empty = count <= (ADDR_W+1)'(AE_TH);
  // Storage is deliberately left out of reset
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= wr_data;
  // Pointers wrap naturally at DEPTH; count tracks net accepted traffic
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_W'(wr_acc);
      rd_ptr <= rd_ptr + ADDR_W'(rd_acc);
      count  <= count + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    end
  end
  // Sticky error flags; a fresh error event outranks a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr_en & full) | (overflow & ~clr_err);
      underflow <= (rd_en & empty) | (underflow & ~clr_err);
    end
  end
  if (FWFT) begin : g_fwft
    assign rd_data  = mem[rd_ptr];
    assign rd_valid = ~empty;
  end else begin : g_reg
    // Registered read: word appears one cycle after its accepted read, otherwise data holds
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= mem[rd_ptr];
      end
    end
  end
endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb_fifo_sync_flags: registered and FWFT FIFOs driven in lockstep and checked against a queue model
module tb_fifo_sync_flags;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AF = DEPTH - 2;
  localparam int AE = 2;
  logic clk = 1'b0, rst = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic full0, af0, rv0, em0, ae0, ov0, un0;
  logic [DW-1:0] rd0;
  logic [4:0] cnt0;
  logic full1, af1, rv1, em1, ae1, ov1, un1;
  logic [DW-1:0] rd1;
  logic [4:0] cnt1;
  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] q[$];
  bit m_ovf, m_unf, m_v0;
  logic [DW-1:0] m_d0;
  always #5 clk = ~clk;
  fifo_sync_flags #(.DATA_W(DW), .DEPTH(DEPTH), .AF_TH(AF), .AE_TH(AE), .FWFT(1'b0)) u_reg (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full0), .almost_full(af0),
    .rd_en(rd_en), .rd_data(rd0), .rd_valid(rv0), .empty(em0), .almost_empty(ae0),
    .count(cnt0), .overflow(ov0), .underflow(un0), .clr_err(clr_err));
  fifo_sync_flags #(.DATA_W(DW), .DEPTH(DEPTH), .AF_TH(AF), .AE_TH(AE), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full1), .almost_full(af1),
    .rd_en(rd_en), .rd_data(rd1), .rd_valid(rv1), .empty(em1), .almost_empty(ae1),
    .count(cnt1), .overflow(ov1), .underflow(un1), .clr_err(clr_err));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model(input bit w, input logic [DW-1:0] d, input bit r, input bit c, input bit rs);
    bit f, e;
    if (rs) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
      m_v0 = 0;
      m_d0 = '0;
      return;
    end
    f = q.size() == DEPTH;
    e = q.size() == 0;
    m_ovf = (w && f) || (m_ovf && !c);
    m_unf = (r && e) || (m_unf && !c);
    m_v0 = r && !e;
    if (m_v0) m_d0 = q.pop_front();
    if (w && !f) q.push_back(d);
  endtask
  task automatic check_all();
    int n = q.size();
    chk("count", 32'(cnt0), n);
    chk("full", 32'(full0), 32'(n == DEPTH));
    chk("empty", 32'(em0), 32'(n == 0));
    chk("almost_full", 32'(af0), 32'(n >= AF));
    chk("almost_empty", 32'(ae0), 32'(n <= AE));
    chk("overflow", 32'(ov0), 32'(m_ovf));
    chk("underflow", 32'(un0), 32'(m_unf));
    chk("rd_valid", 32'(rv0), 32'(m_v0));
    chk("rd_data", 32'(rd0), 32'(m_d0));
    chk("fwft_count", 32'(cnt1), n);
    chk("fwft_flags", {full1, em1, af1, ae1, ov1, un1},
        {n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_unf});
    chk("fwft_rd_valid", 32'(rv1), 32'(n != 0));
    if (n != 0) chk("fwft_rd_data", 32'(rd1), 32'(q[0]));
  endtask
  // One clock: drive at the falling edge, advance the model at the rising edge, sample 1 time unit later
  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit c, input bit rs);
    wr_en = w;
    wr_data = d;
    rd_en = r;
    clr_err = c;
    rst = rs;
    @(posedge clk);
    model(w, d, r, c, rs);
    #1;
    check_all();
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    cyc(1, 8'h99, 1, 1, 1);
    chk("reset_rd_data", 32'(rd0), 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(i), 0, 0, 0);
      if (i == 12) chk("af_not_yet", 32'(af0), 0);
      if (i == 13) chk("af_at_14", 32'(af0), 1);
    end
    chk("p1_full", 32'(full0), 1);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 0, 0);
      chk("p1_order", 32'(rd0), i);
    end
    chk("p1_empty", 32'(em0), 1);
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h30 + i), 0, 0, 0);
    cyc(1, 8'hAA, 0, 0, 0);
    chk("p2_overflow", 32'(ov0), 1);
    cyc(0, 0, 0, 1, 0);
    chk("p2_clear", 32'(ov0), 0);
    cyc(1, 8'hAA, 0, 1, 0);
    chk("p2_error_wins", 32'(ov0), 1);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 0, 0);
      chk("p2_no_aa", 32'(rd0 == 8'hAA), 0);
    end
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    chk("p3_underflow", 32'(un0), 1);
    cyc(1, 8'h55, 1, 0, 0);
    chk("p3_count1", 32'(cnt0), 1);
    cyc(0, 0, 1, 0, 0);
    chk("p3_data55", 32'(rd0), 8'h55);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(1, 8'(i), 0, 0, 0);
    for (int i = 8; i < 48; i++) begin
      cyc(1, 8'(i), 1, 0, 0);
      chk("p4_hold8", 32'(cnt0), 8);
    end
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'hC0 + i), 0, 0, 0);
    cyc(1, 8'hEE, 1, 0, 0);
    chk("p5_count15", 32'(cnt0), 15);
    chk("p5_oldest", 32'(rd0), 8'hC0);
    for (int i = 0; i < 10; i++) cyc(1, 8'(i), i[0], 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 8'h77, 1, 0, 1);
    chk("p5_reset_empty", 32'(em0), 1);
    cyc(1, 8'h11, 0, 0, 0);
    chk("p6_first", {rv1, rd1}, {1'b1, 8'h11});
    cyc(1, 8'h22, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("p6_second", {rv1, rd1}, {1'b1, 8'h22});
    cyc(0, 0, 1, 0, 0);
    chk("p6_drained", 32'(rv1), 0);
    for (int i = 0; i < 3000; i++) begin
      int pw = ((i / 300) % 2 == 0) ? 70 : 30;
      cyc($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < 100 - pw,
          $urandom_range(99) < 3, $urandom_range(999) < 5);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
